// File: rtl/binning_pkg.sv
// Shared constants and width helpers for the 4x4 mask binning / unbinning path.
// Full-resolution defaults live here so the binning and unbinning sides agree.
package binning_pkg;

    localparam int unsigned DEFAULT_KERNEL_SIZE = 4;
    localparam int unsigned DEFAULT_SHIFT       = $clog2(DEFAULT_KERNEL_SIZE);
    localparam int unsigned DEFAULT_HRES        = 1280;
    localparam int unsigned DEFAULT_VRES        = 720;

    function automatic int unsigned hwidth(input int unsigned hres);
        return $clog2(hres);
    endfunction

    function automatic int unsigned vwidth(input int unsigned vres);
        return $clog2(vres);
    endfunction

    localparam int unsigned DEFAULT_BIN_HWIDTH = hwidth(DEFAULT_HRES) - DEFAULT_SHIFT;
    localparam int unsigned DEFAULT_BIN_VWIDTH = vwidth(DEFAULT_VRES) - DEFAULT_SHIFT;

endpackage

// File: rtl/xilinx_true_dual_port_read_first_1_clock_ram.sv
// True dual-port, read-first, single-clock block RAM with an optional output
// register stage (HIGH_PERFORMANCE adds one cycle of read latency).
module xilinx_true_dual_port_read_first_1_clock_ram #(
    parameter int unsigned RAM_WIDTH       = 18,
    parameter int unsigned RAM_DEPTH       = 1024,
    parameter string       RAM_PERFORMANCE = "HIGH_PERFORMANCE",
    localparam int unsigned ADDR_W         = $clog2(RAM_DEPTH)
) (
    input  logic [ADDR_W-1:0]    addra,
    input  logic [ADDR_W-1:0]    addrb,
    input  logic [RAM_WIDTH-1:0] dina,
    input  logic [RAM_WIDTH-1:0] dinb,
    input  logic                 clka,
    input  logic                 wea,
    input  logic                 web,
    input  logic                 ena,
    input  logic                 enb,
    input  logic                 rsta,
    input  logic                 rstb,
    input  logic                 regcea,
    input  logic                 regceb,
    output logic [RAM_WIDTH-1:0] douta,
    output logic [RAM_WIDTH-1:0] doutb
);

    logic [RAM_WIDTH-1:0] ram [RAM_DEPTH];
    logic [RAM_WIDTH-1:0] ram_data_a;
    logic [RAM_WIDTH-1:0] ram_data_b;

    // Both ports share one process so the array has a single driver; reads return old data.
    always_ff @(posedge clka) begin
        if (ena) begin
            if (wea) ram[addra] <= dina;
            ram_data_a <= ram[addra];
        end
        if (enb) begin
            if (web) ram[addrb] <= dinb;
            ram_data_b <= ram[addrb];
        end
    end

    if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_no_out_reg
        assign douta = ram_data_a;
        assign doutb = ram_data_b;
    end else begin : g_out_reg
        logic [RAM_WIDTH-1:0] douta_reg;
        logic [RAM_WIDTH-1:0] doutb_reg;

        always_ff @(posedge clka) begin
            if (rsta)        douta_reg <= '0;
            else if (regcea) douta_reg <= ram_data_a;
            if (rstb)        doutb_reg <= '0;
            else if (regceb) doutb_reg <= ram_data_b;
        end

        assign douta = douta_reg;
        assign doutb = doutb_reg;
    end

endmodule

// File: rtl/unbinning.sv
// Upscales the binned 1-bit mask back to full resolution: two tagged ping-pong
// row buffers, each binned pixel replicated over a KERNEL_SIZE x KERNEL_SIZE block.
module unbinning
    import binning_pkg::*;
#(
    parameter int unsigned  HRES        = DEFAULT_HRES,
    parameter int unsigned  VRES        = DEFAULT_VRES,
    parameter int unsigned  KERNEL_SIZE = DEFAULT_KERNEL_SIZE,
    localparam int unsigned SHIFT       = $clog2(KERNEL_SIZE),
    localparam int unsigned HWIDTH      = hwidth(HRES),
    localparam int unsigned VWIDTH      = vwidth(VRES)
) (
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    input  logic [HWIDTH-SHIFT-1:0]   bin_hcount_in,
    input  logic [VWIDTH-SHIFT-1:0]   bin_vcount_in,
    input  logic                      bin_pixel_in,
    input  logic                      bin_valid_in,
    input  logic [HWIDTH-1:0]         hcount_in,
    input  logic [VWIDTH-1:0]         vcount_in,
    input  logic                      req_valid_in,
    output logic                      pixel_data_out,
    output logic [HWIDTH-1:0]         hcount_out,
    output logic [VWIDTH-1:0]         vcount_out,
    output logic                      data_valid_out,
    output logic                      row_miss_out
);

    localparam int unsigned BIN_HW   = HWIDTH - SHIFT;
    localparam int unsigned BIN_VW   = VWIDTH - SHIFT;
    localparam int unsigned BIN_COLS = HRES / KERNEL_SIZE;
    localparam int unsigned ADDR_W   = $clog2(BIN_COLS);
    localparam logic [BIN_HW-1:0] LAST_COL = BIN_HW'(BIN_COLS - 1);

    logic [BIN_VW-1:0] tag [2];
    logic [1:0]        tag_valid;

    logic [BIN_VW-1:0] req_row;
    logic [ADDR_W-1:0] req_col;
    logic              req_bank;
    logic              hit;

    logic [ADDR_W-1:0] wr_addr;
    logic              wr_bank;
    logic              wr_en;

    logic [1:0]        douta_unused;
    logic [1:0]        doutb;

    logic              valid_q1, valid_q2;
    logic              hit_q1,   hit_q2;
    logic              bank_q1,  bank_q2;
    logic [HWIDTH-1:0] hcount_q1;
    logic [VWIDTH-1:0] vcount_q1;

    assign req_row  = BIN_VW'(vcount_in >> SHIFT);
    assign req_col  = ADDR_W'(hcount_in >> SHIFT);
    assign req_bank = req_row[0];
    assign hit      = tag_valid[req_bank] && (tag[req_bank] == req_row);

    assign wr_bank  = bin_vcount_in[0];
    assign wr_addr  = ADDR_W'(bin_hcount_in);
    assign wr_en    = bin_valid_in && (bin_hcount_in <= LAST_COL);

    // A row becomes resident only once its last column lands; its first column evicts the old row.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int unsigned i = 0; i < 2; i++) tag[i] <= '0;
            tag_valid <= '0;
        end else if (wr_en) begin
            if (bin_hcount_in == '0) tag_valid[wr_bank] <= 1'b0;
            if (bin_hcount_in == LAST_COL) begin
                tag[wr_bank]       <= bin_vcount_in;
                tag_valid[wr_bank] <= 1'b1;
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        xilinx_true_dual_port_read_first_1_clock_ram #(
            .RAM_WIDTH       (1),
            .RAM_DEPTH       (BIN_COLS),
            .RAM_PERFORMANCE ("HIGH_PERFORMANCE")
        ) u_ram (
            .addra  (wr_addr),
            .addrb  (req_col),
            .dina   (bin_pixel_in),
            .dinb   (1'b0),
            .clka   (clk_in),
            .wea    (wr_en && (wr_bank == 1'(b))),
            .web    (1'b0),
            .ena    (1'b1),
            .enb    (1'b1),
            .rsta   (1'b0),
            .rstb   (1'b0),
            .regcea (1'b1),
            .regceb (1'b1),
            .douta  (douta_unused[b]),
            .doutb  (doutb[b])
        );
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            valid_q1   <= 1'b0;
            valid_q2   <= 1'b0;
            hit_q1     <= 1'b0;
            hit_q2     <= 1'b0;
            bank_q1    <= 1'b0;
            bank_q2    <= 1'b0;
            hcount_q1  <= '0;
            vcount_q1  <= '0;
            hcount_out <= '0;
            vcount_out <= '0;
        end else begin
            valid_q1   <= req_valid_in;
            valid_q2   <= valid_q1;
            hit_q1     <= hit;
            hit_q2     <= hit_q1;
            bank_q1    <= req_bank;
            bank_q2    <= bank_q1;
            hcount_q1  <= hcount_in;
            vcount_q1  <= vcount_in;
            hcount_out <= hcount_q1;
            vcount_out <= vcount_q1;
        end
    end

    // Gating by the reset-cleared valid makes these outputs drop to 0 asynchronously.
    assign data_valid_out = valid_q2;
    assign row_miss_out   = valid_q2 & ~hit_q2;
    assign pixel_data_out = valid_q2 & hit_q2 & doutb[bank_q2];

endmodule

// File: doc/unbinning.md
# unbinning

Upscaler that reverses the 4x4 binning of the 1-bit mask path. It accepts the binned stream (HRES/4 x VRES/4) from the downsampler, holds the two most recent binned rows in ping-pong line buffers, and replicates each binned pixel over a KERNEL_SIZE x KERNEL_SIZE block. The full-resolution hcount/vcount scan of the video/display side drives it, and it sits between the mask processing stage and the overlay/compositing stage.

## Interface
- HRES, 1280, full-resolution line width; must be a multiple of KERNEL_SIZE
- VRES, 720, full-resolution frame height; must be a multiple of KERNEL_SIZE
- KERNEL_SIZE, 4, replication factor; power of two; SHIFT = log2(KERNEL_SIZE)
- clk_in  input  1  system clock; sole clock
- rst_n_in  input  1  reset, asynchronous, active-low
- bin_hcount_in  input  HWIDTH-SHIFT  binned column being written
- bin_vcount_in  input  VWIDTH-SHIFT  binned row being written
- bin_pixel_in  input  1  binned mask pixel
- bin_valid_in  input  1  write strobe for the binned pixel
- hcount_in  input  HWIDTH  full-resolution column requested (HWIDTH = $clog2(HRES))
- vcount_in  input  VWIDTH  full-resolution row requested (VWIDTH = $clog2(VRES))
- req_valid_in  input  1  request strobe
- pixel_data_out  output  1  upscaled mask pixel
- hcount_out  output  HWIDTH  hcount_in delayed to align with pixel_data_out
- vcount_out  output  VWIDTH  vcount_in delayed to align with pixel_data_out
- data_valid_out  output  1  output valid
- row_miss_out  output  1  one-cycle pulse: the requested binned row is not resident

## Operation
- Two banks, each HRES/KERNEL_SIZE x 1 bit. Write bank is bin_vcount_in[0].
- Per bank: tag register (binned row number) and tag_valid.
- Write at column 0 on bin_valid_in: clear tag_valid of the target bank in the same cycle the write is issued.
- Write at column HRES/KERNEL_SIZE-1 on bin_valid_in: set tag = bin_vcount_in and set tag_valid. The row is then resident.
- Request decode: r = vcount_in >> SHIFT, c = hcount_in >> SHIFT, bank = r[0]. hit = tag_valid[bank] && tag[bank] == r, sampled in the request cycle.
- Hit: pixel_data_out = stored bit at (bank, c).
- Miss: pixel_data_out = 0, and row_miss_out pulses in the same cycle as data_valid_out.
- Every requested full-resolution pixel within one KxK block returns the same binned bit. No filtering or interpolation.
- Simultaneous write and read:
  - Same bank: the write's tag_valid clear takes effect in the cycle after the write. A read sampled in the same cycle still hits.
  - Different banks: no interaction.
- Writes with bin_valid_in low are ignored. Column values at or above HRES/KERNEL_SIZE are ignored, with no RAM write and no tag update.
- Reset:
  - Clears both tag_valids, all pipeline valids, and all outputs to 0.
  - RAM contents are not cleared. They are unreachable until re-tagged.

## Timing
- Latency is exactly 2 cycles from req_valid_in to data_valid_out. Throughput is one request per cycle, with no backpressure.
- The RAM read is registered on the output (high-performance mode), so hit, hcount and vcount are pipelined 2 stages to match.
- Request column c sampled at T gives pixel_data_out, hcount_out and vcount_out at T+2.
- Reset values: pixel_data_out=0, hcount_out=0, vcount_out=0, data_valid_out=0, row_miss_out=0.
- Reset asserted mid-stream: outputs drop to 0 asynchronously. Requests in flight are discarded.
- After release, the first hit is possible only after one complete binned row has been written.
- Wrap-around: binned row 0 of the next frame overwrites bank 0. Row VRES/KERNEL_SIZE-1 stays in bank 1 until it is overwritten.

## Structure
- Shared package binning_pkg holds:
  - KERNEL_SIZE default and SHIFT
  - HWIDTH/VWIDTH derivation functions
  - binned width localparams, also used by binning_2
- Sub-module: two instances of xilinx_true_dual_port_read_first_1_clock_ram (RAM_WIDTH 1, RAM_DEPTH HRES/KERNEL_SIZE, HIGH_PERFORMANCE).
  - Port A writes.
  - Port B reads.
- Tag/hit logic and the 2-stage alignment pipeline stay in this module. No separate FSM module.

## Test plan
- Reset: hold rst_n_in low, drive requests -> all outputs 0. After release with no writes, a request at (0,0) gives data_valid_out=1 at T+2 with pixel 0 and row_miss_out=1.
- Hit replication:
  - Stimulus: write binned row 0 as alternating 1,0 over 320 columns, then scan vcount 0..3 with hcount 0..1279.
  - Response: pixel_data_out = ((hcount>>2) even) at T+2, hcount_out/vcount_out equal inputs delayed 2, row_miss_out never pulses.
- Miss:
  - Stimulus: with only row 0 written, request vcount=4, hcount=8.
  - Response: pixel_data_out=0 and row_miss_out=1 at T+2.
- Bank replacement:
  - Stimulus: write binned rows 0, 1, 2 (row 2 all 1s).
  - Response: vcount=0 misses; vcount=8 returns 1 for every hcount; vcount=4 still returns row 1 data.
- Simultaneous access:
  - Stimulus: write bank 1 column 0 (row 3) while reading row 2 from bank 0 -> row 2 data intact, no miss.
  - Stimulus: write row 4 column 0 while reading row 2 -> the same-cycle read hits; the next request to row 2 misses.
- Reset mid-scan: pull rst_n_in low during a hit stream -> data_valid_out=0 immediately. After release, requests for row 0 miss until the row is rewritten.
